// File: rtl/key_event_scheduler_pkg.sv
// Shared constants for the key event scheduler: scancodes, command codes,
// key-slot indices and the PS/2 prefix FSM encoding.
package key_sched_pkg;

   localparam logic [7:0] SC_BRK    = 8'hF0;
   localparam logic [7:0] SC_EXT    = 8'hE0;
   localparam logic [7:0] SC_A      = 8'h1C;
   localparam logic [7:0] SC_D      = 8'h23;
   localparam logic [7:0] SC_J      = 8'h3B;
   localparam logic [7:0] SC_L      = 8'h4B;
   localparam logic [7:0] SC_ESC    = 8'h76;
   localparam logic [7:0] SC_SPACE  = 8'h29;
   localparam logic [7:0] SC_1      = 8'h16;
   localparam logic [7:0] SC_2      = 8'h1E;
   localparam logic [7:0] SC_LARROW = 8'h6B;
   localparam logic [7:0] SC_RARROW = 8'h74;

   typedef enum logic [3:0] {
      CMD_NONE     = 4'd0,
      CMD_P1_LEFT  = 4'd1,
      CMD_P1_RIGHT = 4'd2,
      CMD_P2_LEFT  = 4'd3,
      CMD_P2_RIGHT = 4'd4,
      CMD_ESC      = 4'd5,
      CMD_SPACE    = 4'd6,
      CMD_KEY_1    = 4'd7,
      CMD_KEY_2    = 4'd8
   } cmd_t;

   typedef enum logic [1:0] {
      P_IDLE,
      P_BRK,
      P_EXT,
      P_EXT_BRK
   } prefix_state_t;

   // Slot layout of held[]: movement keys in 0..3 (player*2 + right), control keys in 4..7.
   localparam logic [2:0] KI_P1_LEFT  = 3'd0;
   localparam logic [2:0] KI_P1_RIGHT = 3'd1;
   localparam logic [2:0] KI_P2_LEFT  = 3'd2;
   localparam logic [2:0] KI_P2_RIGHT = 3'd3;
   localparam logic [2:0] KI_ESC      = 3'd4;
   localparam logic [2:0] KI_SPACE    = 3'd5;
   localparam logic [2:0] KI_KEY_1    = 3'd6;
   localparam logic [2:0] KI_KEY_2    = 3'd7;

   localparam int REP_W = 6;

   typedef struct packed {
      logic       hit;
      logic [2:0] idx;
   } key_map_t;

   function automatic key_map_t map_base(input logic [7:0] sc);
      key_map_t m;
      m.hit = 1'b1;
      m.idx = KI_P1_LEFT;
      case (sc)
         SC_A:     m.idx = KI_P1_LEFT;
         SC_D:     m.idx = KI_P1_RIGHT;
         SC_J:     m.idx = KI_P2_LEFT;
         SC_L:     m.idx = KI_P2_RIGHT;
         SC_ESC:   m.idx = KI_ESC;
         SC_SPACE: m.idx = KI_SPACE;
         SC_1:     m.idx = KI_KEY_1;
         SC_2:     m.idx = KI_KEY_2;
         default:  m.hit = 1'b0;
      endcase
      return m;
   endfunction

   function automatic key_map_t map_ext(input logic [7:0] sc);
      key_map_t m;
      m.hit = 1'b1;
      m.idx = KI_P2_LEFT;
      case (sc)
         SC_LARROW: m.idx = KI_P2_LEFT;
         SC_RARROW: m.idx = KI_P2_RIGHT;
         default:   m.hit = 1'b0;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/key_event_scheduler_if.sv
// Command handshake between the key event scheduler and the game FSM.
interface key_event_scheduler_if;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [3:0] cmd_code;

   modport master (output cmd_valid, output cmd_code, input cmd_ready);
   modport slave  (input cmd_valid, input cmd_code, output cmd_ready);
endinterface

// File: rtl/key_event_scheduler_ps2_prefix_decoder.sv
// PS/2 byte strobe detection, F0/E0 prefix FSM and scancode-to-slot map.
// KEY_EXT_ARROWS_EN maps extended left/right arrows onto the player 2 slots.
module ps2_prefix_decoder
   import key_sched_pkg::*;
(
   input  logic       clock,
   input  logic       reset,
   input  logic       done,
   input  logic [7:0] tasta,
   output logic       key_ev,
   output logic       key_make,
   output logic [2:0] key_idx
);

   logic          done_q_reg;
   prefix_state_t state_reg, state_next;
   logic          byte_stb;
   key_map_t      base_map;
   key_map_t      ext_map;

   assign byte_stb = done & ~done_q_reg;
   assign base_map = map_base(tasta);

`ifdef KEY_EXT_ARROWS_EN
   assign ext_map = map_ext(tasta);
`else
   assign ext_map = '0;
`endif

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         done_q_reg <= 1'b0;
         state_reg  <= P_IDLE;
      end else begin
         done_q_reg <= done;
         state_reg  <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      key_ev     = 1'b0;
      key_make   = 1'b0;
      key_idx    = 3'd0;
      if (byte_stb) begin
         case (state_reg)
            P_IDLE: begin
               if (tasta == SC_BRK) begin
                  state_next = P_BRK;
               end else if (tasta == SC_EXT) begin
                  state_next = P_EXT;
               end else begin
                  key_ev   = base_map.hit;
                  key_make = 1'b1;
                  key_idx  = base_map.idx;
               end
            end
            P_BRK: begin
               key_ev     = base_map.hit;
               key_idx    = base_map.idx;
               state_next = P_IDLE;
            end
            P_EXT: begin
               if (tasta == SC_BRK) begin
                  state_next = P_EXT_BRK;
               end else begin
                  key_ev     = ext_map.hit;
                  key_make   = 1'b1;
                  key_idx    = ext_map.idx;
                  state_next = P_IDLE;
               end
            end
            P_EXT_BRK: begin
               key_ev     = ext_map.hit;
               key_idx    = ext_map.idx;
               state_next = P_IDLE;
            end
            default: state_next = P_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/key_event_scheduler.sv
// Tracks held game keys and issues at most one command per frame tick:
// control keys by fixed priority, then the two players round-robin with repeat pacing.
module key_event_scheduler
   import key_sched_pkg::*;
#(
   parameter int REPEAT_FRAMES = 4
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  done,
   input  logic [7:0]            tasta,
   input  logic                  frame_tick,
   key_event_scheduler_if.master cmd_if
);

   localparam logic [REP_W-1:0] REP_LOAD = REP_W'(REPEAT_FRAMES - 1);

   logic             key_ev;
   logic             key_make;
   logic [2:0]       key_idx;

   logic [7:0]       held_reg;
   logic [3:0]       ctrl_pend_reg, ctrl_pend_next;
   logic [3:0]       ctrl_set;
   logic [3:0]       ctrl_clr;
   logic [REP_W-1:0] rep_cnt_reg [2];
   logic             rr_reg, rr_next;
   logic             cmd_valid_reg;
   logic [3:0]       cmd_code_reg;

   logic             arb_en;
   logic             grant_any;
   logic [3:0]       grant_code;
   logic [1:0]       grant_p;
   logic [1:0]       elig;
   logic [1:0]       idle_p;
   logic             pl;

   ps2_prefix_decoder u_prefix (
      .clock    (clock),
      .reset    (reset),
      .done     (done),
      .tasta    (tasta),
      .key_ev   (key_ev),
      .key_make (key_make),
      .key_idx  (key_idx)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         held_reg <= '0;
      end else if (key_ev) begin
         held_reg[key_idx] <= key_make;
      end
   end

   // A control make counts only on a fresh press so typematic repeats are dropped.
   always_comb begin
      ctrl_set = '0;
      if (key_ev && key_make && key_idx[2] && !held_reg[key_idx])
         ctrl_set[key_idx[1:0]] = 1'b1;
      ctrl_pend_next = (ctrl_pend_reg & ~ctrl_clr) | ctrl_set;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) ctrl_pend_reg <= '0;
      else        ctrl_pend_reg <= ctrl_pend_next;
   end

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_player
         logic left_held, right_held;
         assign left_held  = held_reg[2*gi];
         assign right_held = held_reg[2*gi+1];
         assign idle_p[gi] = !left_held && !right_held;
         assign elig[gi]   = (left_held ^ right_held) && (rep_cnt_reg[gi] == '0);

         always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
               rep_cnt_reg[gi] <= '0;
            end else if (grant_p[gi]) begin
               rep_cnt_reg[gi] <= REP_LOAD;
            end else if (idle_p[gi]) begin
               rep_cnt_reg[gi] <= '0;
            end else if (frame_tick && rep_cnt_reg[gi] != '0) begin
               rep_cnt_reg[gi] <= rep_cnt_reg[gi] - 1'b1;
            end
         end
      end
   endgenerate

   assign arb_en = frame_tick && (!cmd_valid_reg || cmd_if.cmd_ready);
   assign pl     = elig[rr_reg] ? rr_reg : ~rr_reg;

   always_comb begin
      grant_any  = 1'b0;
      grant_code = CMD_NONE;
      grant_p    = '0;
      ctrl_clr   = '0;
      rr_next    = rr_reg;
      if (arb_en) begin
         if (ctrl_pend_reg[0]) begin
            grant_any  = 1'b1;
            grant_code = CMD_ESC;
            ctrl_clr   = 4'b0001;
         end else if (ctrl_pend_reg[1]) begin
            grant_any  = 1'b1;
            grant_code = CMD_SPACE;
            ctrl_clr   = 4'b0010;
         end else if (ctrl_pend_reg[2]) begin
            grant_any  = 1'b1;
            grant_code = CMD_KEY_1;
            ctrl_clr   = 4'b0100;
         end else if (ctrl_pend_reg[3]) begin
            grant_any  = 1'b1;
            grant_code = CMD_KEY_2;
            ctrl_clr   = 4'b1000;
         end else if (elig[pl]) begin
            // Player codes are laid out as 1 + 2*player + (direction is right).
            grant_any   = 1'b1;
            grant_p[pl] = 1'b1;
            grant_code  = 4'd1 + {2'b00, pl, 1'b0} + {3'b000, !held_reg[{1'b0, pl, 1'b0}]};
            rr_next     = ~pl;
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rr_reg        <= 1'b0;
         cmd_valid_reg <= 1'b0;
         cmd_code_reg  <= CMD_NONE;
      end else begin
         rr_reg <= rr_next;
         if (grant_any) begin
            cmd_valid_reg <= 1'b1;
            cmd_code_reg  <= grant_code;
         end else if (cmd_if.cmd_ready) begin
            cmd_valid_reg <= 1'b0;
            cmd_code_reg  <= CMD_NONE;
         end
      end
   end

   assign cmd_if.cmd_valid = cmd_valid_reg;
   assign cmd_if.cmd_code  = cmd_code_reg;

endmodule

// File: tb/tb_key_event_scheduler.sv
// Directed bench for key_event_scheduler; expected commands are queued with
// the frame tick that should produce them and a forked monitor checks each accept.
module tb_key_event_scheduler;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       done = 1'b0;
   logic       frame_tick = 1'b0;
   logic [7:0] tasta = 8'h00;

   int total = 0;
   int bad = 0;
   int tick_cnt = 0;

   typedef struct {
      logic [3:0] code;
      int         tick;
   } exp_t;
   exp_t exp_q[$];

   logic       in_hs = 1'b0;
   logic [3:0] hs_code = 4'd0;
   int         hs_tick = 0;

   key_event_scheduler_if bus();

   key_event_scheduler #(.REPEAT_FRAMES(4)) dut (
      .clock      (clock),
      .reset      (reset),
      .done       (done),
      .tasta      (tasta),
      .frame_tick (frame_tick),
      .cmd_if     (bus.master)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input int got, input int want);
      total++;
      if (got != want) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, got, want);
      end
   endtask

   task automatic send(input logic [7:0] b);
      tasta = b;
      done  = 1'b1;
      @(posedge clock); #1;
      done  = 1'b0;
      @(posedge clock); #1;
   endtask

   task automatic tick_exp(input int code);
      exp_t e;
      if (code != 0) begin
         e.code = code[3:0];
         e.tick = tick_cnt + 1;
         exp_q.push_back(e);
      end
      frame_tick = 1'b1;
      tick_cnt++;
      @(posedge clock); #1;
      frame_tick = 1'b0;
      repeat (3) @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      done       = 1'b0;
      frame_tick = 1'b0;
      reset      = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      check("reset_valid", int'(bus.cmd_valid), 0);
      check("reset_code", int'(bus.cmd_code), 0);
      reset = 1'b1;
      @(posedge clock); #1;
   endtask

   task automatic phase_end(input string name);
      check(name, exp_q.size(), 0);
      exp_q.delete();
   endtask

   initial begin
      bus.cmd_ready = 1'b1;

      fork
         forever begin
            @(negedge clock);
            if (!reset) begin
               in_hs = 1'b0;
            end else if (bus.cmd_valid) begin
               if (!in_hs) begin
                  in_hs   = 1'b1;
                  hs_code = bus.cmd_code;
                  hs_tick = tick_cnt;
               end else begin
                  check("code_stable", int'(bus.cmd_code), int'(hs_code));
               end
               if (bus.cmd_ready) begin
                  $display("txn: code=%0d tick=%0d", hs_code, hs_tick);
                  if (exp_q.size() == 0) begin
                     check("unexpected_cmd", int'(hs_code), 0);
                  end else begin
                     exp_t e;
                     e = exp_q.pop_front();
                     check("cmd_code", int'(hs_code), int'(e.code));
                     check("cmd_tick", hs_tick, e.tick);
                  end
                  in_hs = 1'b0;
               end
            end
         end
      join_none

      do_reset();

      // Single make, then break: one command only.
      send(8'h1C);
      tick_exp(1);
      send(8'hF0); send(8'h1C);
      repeat (3) tick_exp(0);
      phase_end("single_make_left");

      // D held, typematic resend every 5 frames, served every 4 frames.
      for (int f = 0; f < 10; f++) begin
         if (f % 5 == 0) send(8'h23);
         tick_exp((f % 4 == 0) ? 2 : 0);
      end
      send(8'hF0); send(8'h23);
      tick_exp(0);
      phase_end("held_repeat_left");

      // Two players alternate, each paced by its own repeat counter.
      do_reset();
      send(8'h1C); send(8'h4B);
      tick_exp(1); tick_exp(4); tick_exp(0); tick_exp(0);
      tick_exp(1); tick_exp(4); tick_exp(0); tick_exp(0);
      send(8'hF0); send(8'h1C); send(8'hF0); send(8'h4B);
      tick_exp(0);
      phase_end("two_players_left");

      // Control priority with typematic SPACE repeats.
      send(8'h29); send(8'h29); send(8'h29); send(8'h76);
      tick_exp(5); tick_exp(6); tick_exp(0); tick_exp(0);
      send(8'hF0); send(8'h29); send(8'hF0); send(8'h76);
      phase_end("ctrl_priority_left");

      // Backpressure: one command held across stalled ticks.
      bus.cmd_ready = 1'b0;
      send(8'h16);
      tick_exp(7); tick_exp(0); tick_exp(0);
      check("bp_valid", int'(bus.cmd_valid), 1);
      check("bp_code", int'(bus.cmd_code), 7);
      bus.cmd_ready = 1'b1;
      @(posedge clock); #1;
      check("bp_drop", int'(bus.cmd_valid), 0);
      tick_exp(0); tick_exp(0);
      send(8'hF0); send(8'h16);
      phase_end("backpressure_left");

      // Reset after a lone F0: the next byte is a make.
      send(8'hF0);
      do_reset();
      send(8'h23);
      tick_exp(2);
      send(8'hF0); send(8'h23);
      tick_exp(0);
      phase_end("midbyte_reset_left");

      // Extended left arrow.
      send(8'hE0); send(8'h6B);
`ifdef KEY_EXT_ARROWS_EN
      tick_exp(3);
`else
      tick_exp(0);
`endif
      send(8'hE0); send(8'hF0); send(8'h6B);
      tick_exp(0);
      phase_end("ext_arrow_left");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
